// File: rtl/fmul_pkg.sv
// rtl/fmul_pkg.sv - shared constants and state encoding for the FloatMul normalise/round stage
package fmul_pkg;

    localparam int EXP_BIAS   = 127;
    localparam int EXP_MAX    = 255;
    localparam int FRAC_W     = 23;
    localparam int MANT_W     = 48;
    localparam int EXP_W      = 10;
    localparam int PASS_MAX   = 31;
    localparam int RSHIFT_CAP = 49;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRE    = 3'd1,
        LSHIFT = 3'd2,
        RSHIFT = 3'd3,
        ROUND  = 3'd4,
        HOLD   = 3'd5
    } state_t;

endpackage

// File: rtl/lzc48.sv
// rtl/lzc48.sv - leading-zero count of a 47-bit vector (47 when the vector is zero)
module lzc48 (
    input  logic [46:0] v,
    output logic [5:0]  cnt
);

    // Scanning upward lets the highest set bit overwrite lower ones.
    always_comb begin
        cnt = 6'd47;
        for (int i = 0; i < 47; i++) begin
            if (v[i]) begin
                cnt = 6'(46 - i);
            end
        end
    end

endmodule

// File: rtl/fmul_norm_round.sv
// rtl/fmul_norm_round.sv - iterative normalise and round-to-nearest-even stage of FloatMul
module fmul_norm_round
    import fmul_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic [EXP_W-1:0]    in_exp,
    input  logic [MANT_W-1:0]   in_mant,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_result,
    output logic                out_overflow,
    output logic                out_underflow,
    output logic                out_inexact,
    output logic                busy
);

    localparam logic signed [EXP_W:0] E_ONE  = (EXP_W+1)'(1);
    localparam logic signed [EXP_W:0] E_MAX  = (EXP_W+1)'(EXP_MAX);
    localparam logic signed [EXP_W:0] E_CAP  = (EXP_W+1)'(RSHIFT_CAP);
    localparam logic [5:0]            P_MAX6 = 6'(PASS_MAX);

    state_t                  state, state_nx;
    logic [MANT_W-1:0]       mant_r;
    logic signed [EXP_W:0]   exp_r;
    logic                    sign_r;
    logic                    sticky_r;
    logic                    zero_r;
    logic [5:0]              rem_r;

    // PRE-stage analysis: fold a bit-47 carry in first, then size the shifts.
    logic [MANT_W-1:0]       pre_mant;
    logic signed [EXP_W:0]   pre_exp;
    logic signed [EXP_W:0]   lmax;
    logic signed [EXP_W:0]   rdiff;
    logic                    pre_stk;
    logic [5:0]              lz;
    logic [5:0]              l_amt;
    logic [5:0]              r_amt;

    logic [4:0]              step;
    logic [MANT_W-1:0]       lost_mask;

    logic                    guard;
    logic                    stk;
    logic                    up;
    logic [24:0]             sum;
    logic signed [EXP_W:0]   exp_fin;
    logic                    ovf;
    logic                    inx;
    logic [31:0]             res;

    lzc48 u_lzc (
        .v   (pre_mant[46:0]),
        .cnt (lz)
    );

    always_comb begin
        pre_mant = mant_r[MANT_W-1] ? (mant_r >> 1) : mant_r;
        pre_exp  = mant_r[MANT_W-1] ? (exp_r + E_ONE) : exp_r;
        pre_stk  = mant_r[MANT_W-1] & mant_r[0];
        lmax     = (pre_exp > E_ONE) ? (pre_exp - E_ONE) : '0;
        l_amt    = (lmax < $signed({5'd0, lz})) ? lmax[5:0] : lz;
        rdiff    = E_ONE - pre_exp;
        if (pre_exp >= E_ONE) begin
            r_amt = 6'd0;
        end else if (rdiff > E_CAP) begin
            r_amt = E_CAP[5:0];
        end else begin
            r_amt = rdiff[5:0];
        end
    end

    always_comb begin
        step      = (rem_r > P_MAX6) ? P_MAX6[4:0] : rem_r[4:0];
        lost_mask = (48'd1 << step) - 48'd1;
    end

    always_comb begin
        guard = mant_r[22];
        stk   = (|mant_r[21:0]) | sticky_r;
        up    = guard & (stk | mant_r[23]);
        sum   = {1'b0, mant_r[46:23]} + {24'd0, up};
        // A significand without its hidden bit is subnormal: exponent field 0.
        if (sum[24]) begin
            exp_fin = exp_r + E_ONE;
        end else if (sum[23]) begin
            exp_fin = exp_r;
        end else begin
            exp_fin = '0;
        end
        ovf = (exp_fin >= E_MAX);
        inx = guard | stk;
        if (zero_r) begin
            res = {sign_r, 31'd0};
        end else if (ovf) begin
            res = {sign_r, 8'hFF, 23'd0};
        end else begin
            res = {sign_r, exp_fin[7:0], sum[24] ? 23'd0 : sum[22:0]};
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (in_valid) state_nx = PRE;
            PRE: begin
                if (mant_r == '0) state_nx = ROUND;
                else if (l_amt != 6'd0) state_nx = LSHIFT;
                else if (r_amt != 6'd0) state_nx = RSHIFT;
                else state_nx = ROUND;
            end
            LSHIFT: if (rem_r <= P_MAX6) state_nx = ROUND;
            RSHIFT: if (rem_r <= P_MAX6) state_nx = ROUND;
            ROUND:  state_nx = HOLD;
            HOLD:   if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mant_r        <= '0;
            exp_r         <= '0;
            sign_r        <= 1'b0;
            sticky_r      <= 1'b0;
            zero_r        <= 1'b0;
            rem_r         <= '0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mant_r   <= in_mant;
                    exp_r    <= {in_exp[EXP_W-1], in_exp};
                    sign_r   <= in_sign;
                    sticky_r <= 1'b0;
                    zero_r   <= 1'b0;
                end
                PRE: begin
                    zero_r   <= (mant_r == '0);
                    mant_r   <= pre_mant;
                    sticky_r <= pre_stk;
                    // Right-shifted results land on the minimum normal exponent.
                    exp_r    <= (r_amt != 6'd0) ? E_ONE : pre_exp;
                    rem_r    <= (l_amt != 6'd0) ? l_amt : r_amt;
                end
                LSHIFT: begin
                    mant_r <= mant_r << step;
                    exp_r  <= exp_r - $signed({6'd0, step});
                    rem_r  <= rem_r - {1'b0, step};
                end
                RSHIFT: begin
                    mant_r   <= mant_r >> step;
                    sticky_r <= sticky_r | (|(mant_r & lost_mask));
                    rem_r    <= rem_r - {1'b0, step};
                end
                ROUND: begin
                    out_result    <= res;
                    out_overflow  <= ~zero_r & ovf;
                    out_underflow <= ~zero_r & ~mant_r[46] & inx;
                    out_inexact   <= ~zero_r & inx;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_fmul_norm_round.sv
// tb/tb_fmul_norm_round.sv - directed self-checking bench for fmul_norm_round
module tb_fmul_norm_round;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    fmul_norm_round dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic accept(input logic sgn, input int e, input logic [47:0] m);
        @(negedge clk);
        in_sign  = sgn;
        in_exp   = e[9:0];
        in_mant  = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic sgn, input int e, input logic [47:0] m,
                           input logic [31:0] res, input logic [2:0] flags, input int lat);
        int cyc;
        @(negedge clk);
        check_eq({tag, " in_ready"}, 48'(in_ready), 48'd1);
        accept(sgn, e, m);
        check_eq({tag, " busy"}, 48'(busy), 48'd1);
        wait_valid(cyc);
        check_eq({tag, " latency"}, 48'(cyc), 48'(lat));
        check_eq({tag, " result"}, 48'(out_result), 48'(res));
        check_eq({tag, " ovf/unf/inx"}, 48'({out_overflow, out_underflow, out_inexact}), 48'(flags));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, " release"}, 48'({out_valid, in_ready}), 48'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int cyc;
        int seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset state", 48'({in_ready, out_valid, busy, out_overflow, out_underflow, out_inexact}),
                 48'b100000);
        check_eq("reset result", 48'(out_result), 48'd0);
        @(negedge clk);
        reset = 1'b0;

        run_vec("mul1p5",    1'b0, 127,  48'h900000000000, 32'h40100000, 3'b000, 2);
        run_vec("mul1p0",    1'b0, 127,  48'h400000000000, 32'h3F800000, 3'b000, 2);
        run_vec("deepnorm",  1'b0, 200,  48'h000000000040, 32'h50000000, 3'b000, 4);
        run_vec("overflow",  1'b1, 300,  48'h400000000000, 32'hFF800000, 3'b100, 2);
        run_vec("underflow", 1'b0, -30,  48'h400000000000, 32'h00000000, 3'b011, 3);
        run_vec("tie_even",  1'b0, 127,  48'h400000400000, 32'h3F800000, 3'b001, 2);
        run_vec("tie_odd",   1'b0, 127,  48'h400000C00000, 32'h3F800002, 3'b001, 2);
        run_vec("carryout",  1'b0, 127,  48'h7FFFFFC00000, 32'h40000000, 3'b001, 2);
        run_vec("round_inf", 1'b0, 254,  48'h7FFFFFC00000, 32'h7F800000, 3'b101, 2);
        run_vec("zero",      1'b1, 127,  48'h000000000000, 32'h80000000, 3'b000, 2);
        run_vec("rcap",      1'b0, -100, 48'h400000000000, 32'h00000000, 3'b011, 4);
        run_vec("denorm",    1'b0, -5,   48'h400000000000, 32'h00020000, 3'b000, 3);
        run_vec("lclamp",    1'b0, 3,    48'h010000000000, 32'h00080000, 3'b000, 3);
        run_vec("b47_min",   1'b0, 0,    48'h800000000000, 32'h00800000, 3'b000, 2);

        // Backpressure: result must stay put and new inputs stay ignored.
        accept(1'b0, 127, 48'h900000000000);
        wait_valid(cyc);
        check_eq("bp latency", 48'(cyc), 48'd2);
        @(negedge clk);
        in_valid = 1'b1;
        in_mant  = 48'h400000000000;
        in_exp   = 10'd127;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp hold", 48'({out_valid, in_ready, out_result}), 48'({2'b10, 32'h40100000}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("bp release", 48'({out_valid, in_ready}), 48'b01);

        // Reset while the second-stage left shift is in flight.
        accept(1'b0, 200, 48'h000000000040);
        @(posedge clk);
        #1;
        check_eq("rst pre busy", 48'(busy), 48'd1);
        reset = 1'b1;
        #1;
        check_eq("rst async", 48'({out_valid, in_ready, busy}), 48'b010);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check_eq("rst no result", 48'(seen), 48'd0);
        check_eq("rst idle", 48'({in_ready, busy}), 48'b10);

        run_vec("after_rst", 1'b1, 127, 48'h400000000000, 32'hBF800000, 3'b000, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
